// File: rtl/nibble_serial_cmp_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_cmp_ctrl.
// The producer/consumer side uses the master modport; the comparator uses the slave modport.
interface nibble_serial_cmp_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int DATA_W = 4 * NIBBLES;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] num_a;
    logic [DATA_W-1:0] num_b;
    logic              out_valid;
    logic              out_ready;
    logic              lt;
    logic              eq;
    logic              gt;

    modport master (
        output in_valid, num_a, num_b, out_ready,
        input  in_ready, out_valid, lt, eq, gt
    );

    modport slave (
        input  in_valid, num_a, num_b, out_ready,
        output in_ready, out_valid, lt, eq, gt
    );
endinterface

// File: rtl/nibble_serial_cmp_ctrl.sv
// Serial wide-operand magnitude comparator: one 4-bit cascaded comparator slice is
// reused across the operand, LSB nibble first, the registered slice result feeding
// the next nibble's cascade inputs.
// Optional build macro CMP_SIGNED_EN: two's-complement compare, done by inverting
// bit 3 of both operands' MSB nibble before the slice.
module nibble_serial_cmp_ctrl #(
    parameter int  NIBBLES = 4,
    localparam int DATA_W  = 4 * NIBBLES,
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    nibble_serial_cmp_ctrl_if.slave bus,
    output logic                    busy,
    output logic [IDX_W-1:0]        nib_idx
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]        state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              l_reg, e_reg, g_reg;

    logic [3:0]        a_nib [NIBBLES];
    logic [3:0]        b_nib [NIBBLES];
    logic [3:0]        a_cur, b_cur;
    logic              l_next, e_next, g_next;

    // Split the captured operands into nibbles; the sign fix-up only touches the top one.
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
`ifdef CMP_SIGNED_EN
            if (gi == NIBBLES - 1) begin : g_msb
                assign a_nib[gi] = {~a_reg[gi*4+3], a_reg[gi*4 +: 3]};
                assign b_nib[gi] = {~b_reg[gi*4+3], b_reg[gi*4 +: 3]};
            end else begin : g_lsb
                assign a_nib[gi] = a_reg[gi*4 +: 4];
                assign b_nib[gi] = b_reg[gi*4 +: 4];
            end
`else
            assign a_nib[gi] = a_reg[gi*4 +: 4];
            assign b_nib[gi] = b_reg[gi*4 +: 4];
`endif
        end
    endgenerate

    assign a_cur = a_nib[idx_reg];
    assign b_cur = b_nib[idx_reg];

    // Comparator slice: a differing nibble decides, an equal nibble passes the cascade through.
    always_comb begin
        l_next = l_reg;
        e_next = e_reg;
        g_next = g_reg;
        if (a_cur > b_cur) begin
            l_next = 1'b0;
            e_next = 1'b0;
            g_next = 1'b1;
        end else if (a_cur < b_cur) begin
            l_next = 1'b1;
            e_next = 1'b0;
            g_next = 1'b0;
        end
    end

    // Sequencer: capture in IDLE, one nibble per cycle in RUN, hold the result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            l_reg     <= 1'b0;
            e_reg     <= 1'b1;
            g_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.num_a;
                        b_reg     <= bus.num_b;
                        l_reg     <= 1'b0;
                        e_reg     <= 1'b1;
                        g_reg     <= 1'b0;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    l_reg <= l_next;
                    e_reg <= e_next;
                    g_reg <= g_next;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Handshake and result outputs; flags read zero except while a result is offered.
    always_comb begin
        bus.in_ready  = (state_reg == IDLE) && !rst;
        bus.out_valid = (state_reg == DONE);
        bus.lt        = (state_reg == DONE) && l_reg;
        bus.eq        = (state_reg == DONE) && e_reg;
        bus.gt        = (state_reg == DONE) && g_reg;
        busy          = (state_reg == RUN);
        nib_idx       = idx_reg;
    end
endmodule

// File: tb/tb_nibble_serial_cmp_ctrl.sv
// Self-checking bench for nibble_serial_cmp_ctrl: directed cases, backpressure,
// mid-run reset, randomized compares and a back-to-back streaming run.
module tb_nibble_serial_cmp_ctrl;
    localparam int NIBBLES = 4;
    localparam int DATA_W  = 4 * NIBBLES;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic [IDX_W-1:0] nib_idx;
    int               n_checks = 0;
    int               n_errors = 0;

    nibble_serial_cmp_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_cmp_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .nib_idx (nib_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-operand integer comparison, returned as {lt, eq, gt}.
    function automatic logic [2:0] ref_cmp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef CMP_SIGNED_EN
        if ($signed(a) < $signed(b)) return 3'b100;
        if ($signed(a) > $signed(b)) return 3'b001;
        return 3'b010;
`else
        if (a < b) return 3'b100;
        if (a > b) return 3'b001;
        return 3'b010;
`endif
    endfunction

    function automatic logic [2:0] flags();
        return {bus.lt, bus.eq, bus.gt};
    endfunction

    // One full transaction: offer, accept, watch RUN, hold DONE for 'hold' cycles, drain.
    task automatic run_cmp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input int hold);
        logic [2:0] exp;
        int         lat;
        int         w;
        exp = ref_cmp(a, b);
        @(negedge clk);
        bus.num_a    = a;
        bus.num_b    = b;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.num_a    = DATA_W'($urandom);
        bus.num_b    = DATA_W'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (lat < NIBBLES) begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_nib_idx", 32'(nib_idx), 32'(lat));
                check("run_in_ready", 32'(bus.in_ready), 32'd0);
            end
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(NIBBLES));
        check("flags", 32'(flags()), 32'(exp));
        check("onehot", 32'($countones(flags())), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_flags", 32'(flags()), 32'(exp));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_flags", 32'(flags()), 32'd0);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        $display("cmp a=%h b=%h hold=%0d exp{lt,eq,gt}=%b", a, b, hold, exp);
    endtask

    initial begin
        logic [DATA_W-1:0] a, b;
        logic [2:0]        exp_q[$];
        logic [2:0]        e;
        int                last_cyc, n_res, gap;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.num_a    = '0;
        bus.num_b    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_nib_idx", 32'(nib_idx), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed cases, including the sign-sensitive ones and a 5-cycle backpressure hold.
        run_cmp(16'h1234, 16'h1234, 0);
        run_cmp(16'h0001, 16'h0002, 1);
        run_cmp(16'h2000, 16'h1FFF, 0);
        run_cmp(16'h8000, 16'h7FFF, 5);
        run_cmp(16'hFFFF, 16'h0000, 2);

        // Reset while RUN is at nibble 2: everything returns to reset values.
        @(negedge clk);
        bus.num_a    = 16'h0F0F;
        bus.num_b    = 16'h0F0E;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_nib_idx", 32'(nib_idx), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_nib_idx", 32'(nib_idx), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid2", 32'(bus.out_valid), 32'd0);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        run_cmp(16'h4321, 16'h4322, 0);

        // Randomized compares, biased towards equal or nearly-equal operands.
        for (int i = 0; i < 30; i++) begin
            a = DATA_W'($urandom);
            case ($urandom_range(0, 2))
                0: b = a;
                1: b = a ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1));
                default: b = DATA_W'($urandom);
            endcase
            run_cmp(a, b, $urandom_range(0, 3));
        end

        // Back-to-back stream: in_valid and out_ready held high, one result per NIBBLES+2 cycles.
        @(negedge clk);
        bus.num_a     = DATA_W'($urandom);
        bus.num_b     = DATA_W'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        last_cyc = -1;
        n_res    = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_flags", 32'(flags()), 32'(e));
                end
                check("stream_onehot", 32'($countones(flags())), 32'd1);
                if (last_cyc >= 0) begin
                    gap = cyc - last_cyc;
                    check("stream_interval", 32'(gap), 32'(NIBBLES + 2));
                end
                last_cyc = cyc;
                n_res++;
                $display("stream result %0d at cycle %0d {lt,eq,gt}=%b", n_res, cyc, flags());
            end
            if (bus.in_ready && bus.in_valid) begin
                exp_q.push_back(ref_cmp(bus.num_a, bus.num_b));
            end else begin
                bus.num_a = DATA_W'($urandom);
                bus.num_b = ($urandom_range(0, 1) == 0) ? bus.num_a : DATA_W'($urandom);
            end
            if (cyc == 70) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check("stream_count_ok", 32'(n_res >= 10), 32'd1);
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        bus.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
